encoder_decimal_to_bcd: RTL and testbench

- Converts a 10-bit one-hot decimal digit line (bit i = digit i, i = 0..9) into a 4-bit BCD code.
- Output is registered, with one cycle of latency.
- Flags inputs that are all-zero or multi-hot.
- Sits at the front of digit-entry and display paths, for example keypad to BCD datapath.

---
 rtl/encoder_decimal_to_bcd_pkg.sv | 10 +
 rtl/encoder_decimal_to_bcd_if.sv | 21 ++
 rtl/encoder_decimal_to_bcd_onehot_popcount_check.sv | 32 +++
 rtl/encoder_decimal_to_bcd.sv | 59 +++++
 tb/tb_encoder_decimal_to_bcd.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/encoder_decimal_to_bcd_pkg.sv
// Shared widths, types and defaults for the decimal-to-BCD encoder.
package enc_pkg;
  localparam int DEC_W = 10;
  localparam int BCD_W = 4;

  typedef logic [DEC_W-1:0] dec_onehot_t;
  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t DEFAULT_INVALID_CODE = 4'hF;
endpackage

// File: rtl/encoder_decimal_to_bcd_if.sv
// Request/response bundle between a digit source and the encoder.
interface encoder_decimal_to_bcd_if;
  import enc_pkg::*;

  logic        in_valid;
  dec_onehot_t decimal_in;
  bcd_t        bcd;
  logic        out_valid;
  logic        none_hot;
  logic        multi_hot;

  modport master (
    output in_valid, decimal_in,
    input  bcd, out_valid, none_hot, multi_hot
  );

  modport slave (
    input  in_valid, decimal_in,
    output bcd, out_valid, none_hot, multi_hot
  );
endinterface

// File: rtl/encoder_decimal_to_bcd_onehot_popcount_check.sv
// Combinational population count and priority index search over the digit line.
module onehot_popcount_check
  import enc_pkg::*;
(
  input  dec_onehot_t decimal_in_i,
  output logic        is_zero_o,
  output logic        is_multi_o,
  output bcd_t        idx_msb_o,
  output bcd_t        idx_lsb_o
);

  logic [3:0] cnt;

  // Count set bits; zero and two-or-more are the error classes.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEC_W; i++) cnt = cnt + 4'(decimal_in_i[i]);
    is_zero_o  = (cnt == 4'd0);
    is_multi_o = (cnt > 4'd1);
  end

  // Ascending scan leaves the highest set bit; descending scan the lowest.
  always_comb begin
    idx_msb_o = '0;
    idx_lsb_o = '0;
    for (int i = 0; i < DEC_W; i++)
      if (decimal_in_i[i]) idx_msb_o = 4'(i);
    for (int i = DEC_W-1; i >= 0; i--)
      if (decimal_in_i[i]) idx_lsb_o = 4'(i);
  end

endmodule

// File: rtl/encoder_decimal_to_bcd.sv
// One-hot decimal digit to BCD encoder with a single register stage and
// zero/multi-hot flags. No backpressure; accepts a digit every cycle.
module encoder_decimal_to_bcd
  import enc_pkg::*;
#(
  parameter bit   PRIORITY_MSB = 1'b1,
  parameter bcd_t INVALID_CODE = DEFAULT_INVALID_CODE
) (
  input logic                      clk,
  input logic                      rst,
  encoder_decimal_to_bcd_if.slave  bus
);

  logic is_zero, is_multi;
  bcd_t idx_msb, idx_lsb;

  bcd_t bcd_d, bcd_q;
  logic none_d, none_q;
  logic multi_d, multi_q;
  logic vld_q;

  onehot_popcount_check u_chk (
    .decimal_in_i (bus.decimal_in),
    .is_zero_o    (is_zero),
    .is_multi_o   (is_multi),
    .idx_msb_o    (idx_msb),
    .idx_lsb_o    (idx_lsb)
  );

  // Pick the priority direction and substitute the invalid code for an empty line.
  always_comb begin
    bcd_d   = is_zero ? INVALID_CODE : (PRIORITY_MSB ? idx_msb : idx_lsb);
    none_d  = is_zero;
    multi_d = is_multi;
  end

  // Output register: valid follows in_valid, data/flags hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      bcd_q   <= '0;
      none_q  <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      vld_q <= bus.in_valid;
      if (bus.in_valid) begin
        bcd_q   <= bcd_d;
        none_q  <= none_d;
        multi_q <= multi_d;
      end
    end
  end

  assign bus.bcd       = bcd_q;
  assign bus.out_valid = vld_q;
  assign bus.none_hot  = none_q;
  assign bus.multi_hot = multi_q;

endmodule

// File: tb/tb_encoder_decimal_to_bcd.sv
// Bench for encoder_decimal_to_bcd: two instances (MSB and LSB priority)
// driven by the same directed stream, checked against a behavioural model
// every cycle plus hand-computed literal expectations.
module tb_encoder_decimal_to_bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [9:0] decimal_in;

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  encoder_decimal_to_bcd_if if_m ();
  encoder_decimal_to_bcd_if if_l ();

  assign if_m.in_valid   = in_valid;
  assign if_m.decimal_in = decimal_in;
  assign if_l.in_valid   = in_valid;
  assign if_l.decimal_in = decimal_in;

  encoder_decimal_to_bcd #(.PRIORITY_MSB(1'b1), .INVALID_CODE(4'hF)) u_msb (
    .clk (clk), .rst (rst), .bus (if_m)
  );
  encoder_decimal_to_bcd #(.PRIORITY_MSB(1'b0), .INVALID_CODE(4'hF)) u_lsb (
    .clk (clk), .rst (rst), .bus (if_l)
  );

  // Packed view {out_valid, none_hot, multi_hot, bcd[3:0]}.
  function automatic logic [6:0] pk(input logic v, input logic n, input logic m, input logic [3:0] b);
    return {v, n, m, b};
  endfunction

  // Behavioural encode: {none, multi, bcd} from the digit-line rules.
  function automatic logic [5:0] enc(input logic [9:0] d, input bit msb);
    int n;
    int idx;
    n = $countones(d);
    if (n == 0) return {1'b1, 1'b0, 4'hF};
    idx = -1;
    if (msb) begin
      for (int i = 9; i >= 0; i--) if (d[i] && idx < 0) idx = i;
    end else begin
      for (int i = 0; i <= 9; i++) if (d[i] && idx < 0) idx = i;
    end
    return {1'b0, (n >= 2), 4'(idx)};
  endfunction

  logic [6:0] m_msb, m_lsb;

  // Reference model: registered view of the expected outputs.
  always @(posedge clk) begin
    if (rst) begin
      m_msb <= 7'b0;
      m_lsb <= 7'b0;
    end else if (in_valid) begin
      m_msb <= {1'b1, enc(decimal_in, 1'b1)};
      m_lsb <= {1'b1, enc(decimal_in, 1'b0)};
    end else begin
      m_msb <= {1'b0, m_msb[5:0]};
      m_lsb <= {1'b0, m_lsb[5:0]};
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {v,n,m,bcd}=%b required %b", name, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("model_msb", pk(if_m.out_valid, if_m.none_hot, if_m.multi_hot, if_m.bcd), m_msb);
      chk("model_lsb", pk(if_l.out_valid, if_l.none_hot, if_l.multi_hot, if_l.bcd), m_lsb);
    end
  end

  // Drive one cycle of inputs, let the edge happen, sample shortly after.
  task automatic apply(input logic r, input logic v, input logic [9:0] d);
    @(negedge clk);
    rst = r; in_valid = v; decimal_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [6:0] em, input logic [6:0] el);
    chk({name, "_msb"}, pk(if_m.out_valid, if_m.none_hot, if_m.multi_hot, if_m.bcd), em);
    chk({name, "_lsb"}, pk(if_l.out_valid, if_l.none_hot, if_l.multi_hot, if_l.bcd), el);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; decimal_in = 10'h200;

    // Reset held two cycles with a valid digit present.
    apply(1'b1, 1'b1, 10'h200);
    apply(1'b1, 1'b1, 10'h200);
    armed = 1'b1;
    lit("reset", 7'b000_0000, 7'b000_0000);

    // One-hot sweep.
    for (int i = 0; i < 10; i++) begin
      logic [9:0] d;
      d = 10'(1) << i;
      apply(1'b0, 1'b1, d);
      lit($sformatf("onehot%0d", i), {3'b100, 4'(i)}, {3'b100, 4'(i)});
    end

    // Empty line.
    apply(1'b0, 1'b1, 10'h000);
    lit("zero", 7'b110_1111, 7'b110_1111);

    // Multi-hot priority resolution.
    apply(1'b0, 1'b1, 10'b10_0000_0100);
    lit("multi_9_2", 7'b101_1001, 7'b101_0010);
    apply(1'b0, 1'b1, 10'h3FF);
    lit("all_hot", 7'b101_1001, 7'b101_0000);
    apply(1'b0, 1'b1, 10'h0C0);
    lit("multi_7_6", 7'b101_0111, 7'b101_0110);

    // Hold when idle.
    apply(1'b0, 1'b1, 10'h020);
    lit("digit5", 7'b100_0101, 7'b100_0101);
    apply(1'b0, 1'b0, 10'h001);
    lit("hold5", 7'b000_0101, 7'b000_0101);
    apply(1'b0, 1'b0, 10'h000);
    lit("hold5b", 7'b000_0101, 7'b000_0101);

    // Back-to-back stream with reset during the middle digit.
    apply(1'b0, 1'b1, 10'h008);
    lit("stream3", 7'b100_0011, 7'b100_0011);
    apply(1'b1, 1'b1, 10'h080);
    lit("stream_rst", 7'b000_0000, 7'b000_0000);
    apply(1'b0, 1'b1, 10'h002);
    lit("stream1", 7'b100_0001, 7'b100_0001);

    // Flags cleared by a clean digit after multi/zero.
    apply(1'b0, 1'b1, 10'h000);
    apply(1'b0, 1'b1, 10'h00A);
    lit("multi_3_1", 7'b101_0011, 7'b101_0001);
    apply(1'b0, 1'b1, 10'h100);
    lit("clean8", 7'b100_1000, 7'b100_1000);

    apply(1'b0, 1'b0, 10'h000);
    @(negedge clk);
    armed = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net: the run is short and bounded.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish required finish by 100000");
    $fatal(1);
  end

endmodule
